// File: rtl/grid_array.sv
// grid_array: WIDTH x HEIGHT SIMD cellular-automaton array.
//
// Every cell is a `core` that executes the broadcast instruction against its
// own state and its four von Neumann neighbours. Around the array sit a
// two-stage branch-consensus reduction and a raster readout engine that
// freezes the cores while it streams one coherent frame.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   next_program_counter          broadcast program counter
//   next_stack_pointer            broadcast stack pointer
//   instruction                   broadcast instruction
//   global_enable                 execution enable from global control
//   diverge_consensus             registered AND of all core diverge flags
//   readout_start/abort/busy      frame request, abandon, scan-in-progress
//   pix_valid/ready/data          pixel stream handshake and value
//   pix_sof/eol/eof               frame, line and last-pixel markers
//   frames_done                   completed-frame counter (wraps)
//
// Instruction word: [11:8] opcode, [7:0] immediate.
//   0 NOP     1 LDI imm   2 copy north (i01)  3 copy west (i10)
//   4 copy east (i12)     5 copy south (i21)  6 ADDI imm
//   7 load pc             8 load sp           9 set diverge
//   A diverge <= (state != imm)               others NOP

typedef logic [7:0]  value_t;
typedef logic [7:0]  pc_t;
typedef logic [7:0]  sp_t;
typedef logic [11:0] instruction_t;

// Readout FSM
//   state | meaning
//   IDLE  | cores run, no pixels offered, counters parked at (0,0)
//   SCAN  | cores frozen, pixel (x_cnt, y_cnt) offered on the stream
module grid_array #(
  parameter int     WIDTH        = 25,
  parameter int     HEIGHT       = 25,
  parameter int     BOUNDARY     = 0,
  parameter value_t BORDER_VALUE = '0,
  parameter int     CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  pc_t                next_program_counter,
  input  sp_t                next_stack_pointer,
  input  instruction_t       instruction,
  input  logic               global_enable,
  output logic               diverge_consensus,
  input  logic               readout_start,
  input  logic               readout_abort,
  output logic               readout_busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output value_t             pix_data,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic [CNT_W-1:0]   frames_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } rd_state_t;

  value_t video   [HEIGHT][WIDTH];
  logic   div_arr [HEIGHT][WIDTH];
  logic   core_en;

  rd_state_t          state_q, state_d;
  logic               busy_q, busy_d;
  logic [XW-1:0]      x_cnt_q, x_cnt_d;
  logic [YW-1:0]      y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic [HEIGHT-1:0]  row_and_q, row_and_d;
  logic               consensus_q, consensus_d;

  // The freeze comes from the registered busy flag, so the cycle in which
  // start is sampled still updates the array.
  assign core_en = global_enable & ~busy_q;

  for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
    for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
      localparam int  YU     = (gy == 0)          ? HEIGHT - 1 : gy - 1;
      localparam int  YD     = (gy == HEIGHT - 1) ? 0          : gy + 1;
      localparam int  XL     = (gx == 0)          ? WIDTH - 1  : gx - 1;
      localparam int  XR     = (gx == WIDTH - 1)  ? 0          : gx + 1;
      // Off-grid neighbours only exist in fixed-border mode.
      localparam bit  EDGE_U = (BOUNDARY == 1) && (gy == 0);
      localparam bit  EDGE_D = (BOUNDARY == 1) && (gy == HEIGHT - 1);
      localparam bit  EDGE_L = (BOUNDARY == 1) && (gx == 0);
      localparam bit  EDGE_R = (BOUNDARY == 1) && (gx == WIDTH - 1);

      value_t n01, n10, n12, n21;

      assign n01 = EDGE_U ? BORDER_VALUE : video[YU][gx];
      assign n21 = EDGE_D ? BORDER_VALUE : video[YD][gx];
      assign n10 = EDGE_L ? BORDER_VALUE : video[gy][XL];
      assign n12 = EDGE_R ? BORDER_VALUE : video[gy][XR];

      core #(.X(gx), .Y(gy)) u_core (
        .clk         (clk),
        .rst         (rst),
        .en          (core_en),
        .pc          (next_program_counter),
        .sp          (next_stack_pointer),
        .instruction (instruction),
        .i01         (n01),
        .i10         (n10),
        .i11         (video[gy][gx]),
        .i12         (n12),
        .i21         (n21),
        .video       (video[gy][gx]),
        .diverge     (div_arr[gy][gx])
      );
    end
  end

  always_comb begin
    row_and_d = '1;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        row_and_d[y] = row_and_d[y] & div_arr[y][x];
      end
    end
    consensus_d = &row_and_q;
  end

  always_comb begin
    state_d  = state_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        // Abort alongside start cancels the request.
        if (readout_start && !readout_abort) begin
          state_d = SCAN;
          x_cnt_d = '0;
          y_cnt_d = '0;
        end
      end
      SCAN: begin
        // Abort wins over a simultaneous final transfer.
        if (readout_abort) begin
          state_d = IDLE;
          x_cnt_d = '0;
          y_cnt_d = '0;
        end else if (pix_ready) begin
          if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            if (y_cnt_q == Y_LAST) begin
              state_d  = IDLE;
              y_cnt_d  = '0;
              frames_d = frames_q + CNT_W'(1);
            end else begin
              y_cnt_d = y_cnt_q + YW'(1);
            end
          end else begin
            x_cnt_d = x_cnt_q + XW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        x_cnt_d = '0;
        y_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      frames_q    <= '0;
      row_and_q   <= '0;
      consensus_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      frames_q    <= frames_d;
      row_and_q   <= row_and_d;
      consensus_q <= consensus_d;
    end
  end

  assign diverge_consensus = consensus_q;
  assign readout_busy      = busy_q;
  assign pix_valid         = busy_q;
  assign frames_done       = frames_q;
  // Counters sit at (0,0) in IDLE, so this shows video[0][0] there.
  assign pix_data          = video[y_cnt_q][x_cnt_q];
  assign pix_sof           = busy_q && (x_cnt_q == '0) && (y_cnt_q == '0);
  assign pix_eol           = busy_q && (x_cnt_q == X_LAST);
  assign pix_eof           = pix_eol && (y_cnt_q == Y_LAST);

endmodule

// core: one SIMD cell. Holds an 8-bit state (preloaded with 10*Y+X) and a
// diverge flag; executes the broadcast instruction when en is high.
//
// Ports:
//   clk, rst, en                  clock, async reset, execution enable
//   pc, sp, instruction           broadcast operands
//   i01, i10, i11, i12, i21       north, west, self, east, south values
//   video                         current state
//   diverge                       branch-divergence flag
module core #(
  parameter int X = 0,
  parameter int Y = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  pc_t          pc,
  input  sp_t          sp,
  input  instruction_t instruction,
  input  value_t       i01,
  input  value_t       i10,
  input  value_t       i11,
  input  value_t       i12,
  input  value_t       i21,
  output value_t       video,
  output logic         diverge
);

  localparam value_t INIT = value_t'(10 * Y + X);

  logic [3:0] op;
  value_t     imm;
  value_t     state_q, state_d;
  logic       div_q, div_d;

  assign op  = instruction[11:8];
  assign imm = instruction[7:0];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    if (en) begin
      case (op)
        4'h1:    state_d = imm;
        4'h2:    state_d = i01;
        4'h3:    state_d = i10;
        4'h4:    state_d = i12;
        4'h5:    state_d = i21;
        4'h6:    state_d = i11 + imm;
        4'h7:    state_d = pc;
        4'h8:    state_d = sp;
        4'h9:    div_d   = 1'b1;
        4'hA:    div_d   = (i11 != imm);
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  assign video   = state_q;
  assign diverge = div_q;

endmodule

// File: tb/tb_grid_array.sv
// Bench for grid_array: a torus instance and a fixed-border instance share
// all stimulus. A reference model of the cell states predicts every frame;
// expected pixels are queued when a frame is requested and popped on each
// transfer.
module tb_grid_array;

  localparam int W = 4;
  localparam int H = 3;
  localparam logic [7:0] BV = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  npc, nsp;
  logic [11:0] instr;
  logic        gen, rd_start, rd_abort, pix_ready;

  logic        cons_t, busy_t, valid_t, sof_t, eol_t, eof_t;
  logic [7:0]  data_t;
  logic [15:0] frames_t;
  logic        cons_b, busy_b, valid_b, sof_b, eol_b, eof_b;
  logic [7:0]  data_b;
  logic [15:0] frames_b;

  always #5 clk = ~clk;

  grid_array #(.WIDTH(W), .HEIGHT(H), .BOUNDARY(0), .BORDER_VALUE(8'h00), .CNT_W(16)) dut_t (
    .clk(clk), .rst(rst), .next_program_counter(npc), .next_stack_pointer(nsp),
    .instruction(instr), .global_enable(gen), .diverge_consensus(cons_t),
    .readout_start(rd_start), .readout_abort(rd_abort), .readout_busy(busy_t),
    .pix_valid(valid_t), .pix_ready(pix_ready), .pix_data(data_t),
    .pix_sof(sof_t), .pix_eol(eol_t), .pix_eof(eof_t), .frames_done(frames_t));

  grid_array #(.WIDTH(W), .HEIGHT(H), .BOUNDARY(1), .BORDER_VALUE(BV), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .next_program_counter(npc), .next_stack_pointer(nsp),
    .instruction(instr), .global_enable(gen), .diverge_consensus(cons_b),
    .readout_start(rd_start), .readout_abort(rd_abort), .readout_busy(busy_b),
    .pix_valid(valid_b), .pix_ready(pix_ready), .pix_data(data_b),
    .pix_sof(sof_b), .pix_eol(eol_b), .pix_eof(eof_b), .frames_done(frames_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mt [H][W];
  logic [7:0]  mb [H][W];
  bit          m_busy;
  int          m_cnt;
  int          m_frames;
  logic [10:0] q_t[$];
  logic [10:0] q_b[$];
  bit          prev_stall [2];
  logic [10:0] prev_pix [2];
  int          busy_cycles;

  task automatic model_reset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        mt[y][x] = 8'(10 * y + x);
        mb[y][x] = 8'(10 * y + x);
      end
    m_busy = 0;
    m_cnt = 0;
    m_frames = 0;
    q_t.delete();
    q_b.delete();
  endtask

  task automatic apply_op(input bit bd);
    logic [7:0] g [H][W];
    logic [7:0] n01, n10, n12, n21, nv;
    logic [3:0] op;
    logic [7:0] imm;
    op  = instr[11:8];
    imm = instr[7:0];
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        g[y][x] = bd ? mb[y][x] : mt[y][x];
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n01 = (bd && y == 0)     ? BV : g[(y + H - 1) % H][x];
        n21 = (bd && y == H - 1) ? BV : g[(y + 1) % H][x];
        n10 = (bd && x == 0)     ? BV : g[y][(x + W - 1) % W];
        n12 = (bd && x == W - 1) ? BV : g[y][(x + 1) % W];
        case (op)
          4'h1:    nv = imm;
          4'h2:    nv = n01;
          4'h3:    nv = n10;
          4'h4:    nv = n12;
          4'h5:    nv = n21;
          4'h6:    nv = g[y][x] + imm;
          4'h7:    nv = npc;
          4'h8:    nv = nsp;
          default: nv = g[y][x];
        endcase
        if (bd) mb[y][x] = nv;
        else    mt[y][x] = nv;
      end
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        q_t.push_back({mt[y][x], (x == 0 && y == 0), (x == W - 1), (x == W - 1 && y == H - 1)});
        q_b.push_back({mb[y][x], (x == 0 && y == 0), (x == W - 1), (x == W - 1 && y == H - 1)});
      end
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (gen) begin
        apply_op(0);
        apply_op(1);
      end
      if (rd_start && !rd_abort) begin
        m_busy = 1;
        m_cnt = 0;
        push_frame();
      end
    end else if (rd_abort) begin
      m_busy = 0;
      q_t.delete();
      q_b.delete();
    end else if (pix_ready) begin
      m_cnt++;
      if (m_cnt == W * H) begin
        m_busy = 0;
        m_frames++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_step();
  end

  // ---------------- output monitor ----------------
  task automatic mon(input bit bd, input logic v, input logic [10:0] cur,
                     input logic [15:0] fr, input logic bz);
    logic [10:0] e;
    logic [7:0]  d00;
    d00 = bd ? mb[0][0] : mt[0][0];
    chk(bd ? "busy_b" : "busy_t", bz, m_busy);
    chk(bd ? "frames_b" : "frames_t", fr, m_frames);
    if (prev_stall[bd] && v) chk(bd ? "hold_b" : "hold_t", cur, prev_pix[bd]);
    if (!m_busy) begin
      chk(bd ? "idle_b" : "idle_t", {v, cur}, {1'b0, d00, 3'b000});
    end else if (v && pix_ready && !rd_abort) begin
      if ((bd ? q_b.size() : q_t.size()) == 0) begin
        chk(bd ? "extra_pix_b" : "extra_pix_t", 1, 0);
      end else begin
        e = bd ? q_b.pop_front() : q_t.pop_front();
        chk(bd ? "pix_b" : "pix_t", cur, e);
      end
    end
    if (!bd && bz) busy_cycles++;
    prev_stall[bd] = v && !pix_ready && !rd_abort;
    prev_pix[bd]   = cur;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall[0] = 0;
      prev_stall[1] = 0;
    end else begin
      mon(0, valid_t, {data_t, sof_t, eol_t, eof_t}, frames_t, busy_t);
      mon(1, valid_b, {data_b, sof_b, eol_b, eof_b}, frames_b, busy_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy_t", busy_t, 0);
    chk("rst_valid_t", valid_t, 0);
    chk("rst_frames_t", frames_t, 0);
    chk("rst_cons_t", cons_t, 0);
    chk("rst_marks_t", {sof_t, eol_t, eof_t}, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_valid_b", valid_b, 0);
    chk("rst_frames_b", frames_b, 0);
    chk("rst_cons_b", cons_b, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1;
    model_reset();
    #1;
    chk_reset_outs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (m_busy && n < 400) begin
      if (rnd) begin
        pix_ready = 1'($urandom_range(0, 1));
        rd_start  = (n == 3);
      end
      tick();
      n++;
    end
    rd_start  = 0;
    pix_ready = 1;
    if (m_busy) chk("frame_timeout", 1, 0);
  endtask

  task automatic frame(input logic [11:0] op, input bit rnd);
    instr = op;
    rd_start = 1;
    tick();
    rd_start = 0;
    instr = 12'h000;
    wait_idle(rnd);
  endtask

  logic [11:0] ops [8] = '{12'h300, 12'h200, 12'h400, 12'h500,
                           12'h607, 12'h700, 12'h800, 12'h142};
  logic        cons_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [11:0] cons_ins [7] = '{12'h000, 12'h000, 12'h000, 12'hA0C,
                                12'h000, 12'h000, 12'h000};

  initial begin
    int fr_before;
    rst = 1;
    npc = 8'hC3;
    nsp = 8'h5A;
    instr = 12'h000;
    gen = 1;
    rd_start = 0;
    rd_abort = 0;
    pix_ready = 1;
    model_reset();
    busy_cycles = 0;
    #2;
    chk_reset_outs();
    @(posedge clk);
    #1;
    rst = 0;

    // First frame of the preloaded state at full rate.
    busy_cycles = 0;
    frame(12'h000, 0);
    chk("busy_cycles", busy_cycles, 12);
    chk("frames_after_first", frames_t, 1);

    // Shift west in the start cycle, then try to add during the scan with
    // a stalling consumer and a stray start; follow with a check frame.
    instr = 12'h300;
    rd_start = 1;
    tick();
    rd_start = 0;
    instr = 12'h601;
    wait_idle(1);
    instr = 12'h000;
    frame(12'h000, 0);

    // Disabled array ignores the instruction.
    gen = 0;
    instr = 12'h6F0;
    tick();
    gen = 1;
    frame(12'h000, 1);

    // Each operation from the preload on both boundary modes.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      frame(ops[i], 0);
    end

    // Abort after five transfers, then a clean restart from (0,0).
    fr_before = m_frames;
    rd_start = 1;
    tick();
    rd_start = 0;
    repeat (5) tick();
    rd_abort = 1;
    tick();
    rd_abort = 0;
    chk("abort_busy", busy_t, 0);
    chk("abort_frames", frames_t, 16'(fr_before));
    rd_abort = 1;
    tick();
    rd_abort = 0;
    chk("abort_idle_noeffect", busy_t, 0);
    rd_start = 1;
    rd_abort = 1;
    tick();
    rd_start = 0;
    rd_abort = 0;
    chk("start_abort_idle", busy_t, 0);
    frame(12'h000, 0);

    // Asynchronous reset in the middle of a scan.
    rd_start = 1;
    tick();
    rd_start = 0;
    repeat (3) tick();
    do_reset();
    frame(12'h000, 0);

    // Branch consensus: all cells diverge, then cell (2,1) (state 12) drops.
    do_reset();
    instr = 12'h900;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("cons_t", cons_t, cons_exp[i]);
      chk("cons_b", cons_b, cons_exp[i]);
      instr = cons_ins[i];
      tick();
    end
    instr = 12'h000;

    chk("queue_empty_t", q_t.size(), 0);
    chk("queue_empty_b", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
